// File: rtl/mix_add_round_key_stage.sv
// AES-128 round back end: column-serial MixColumns (skipped in the final round)
// followed by AddRoundKey, with valid/ready handshakes on input and output.
module mix_add_round_key_stage #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COLS = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_add_round_key_stage: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [1:0]   r_state;
  logic [127:0] r_in;
  logic [127:0] r_key;
  logic         r_last;
  logic [1:0]   r_col_cnt;
  logic [31:0]  r_res [4];

  logic [31:0]  w_in_col  [4];
  logic [31:0]  w_key_col [4];
  logic [1:0]   w_idx     [COLS_PER_CYCLE];
  logic [31:0]  w_new     [COLS_PER_CYCLE];
  logic         w_accept;
  logic         w_last_write;

  // Ready is forced low during reset; HOLD can take a new block while handing off the old one.
  assign in_ready     = rst_n && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
  assign w_accept     = in_valid && in_ready;
  assign out_valid    = (r_state == S_HOLD);
  assign busy         = (r_state != S_IDLE);
  assign out          = {r_res[0], r_res[1], r_res[2], r_res[3]};
  assign w_last_write = (w_idx[COLS_PER_CYCLE-1] == 2'd3);

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_in_col[c]  = r_in[127-32*c -: 32];
      w_key_col[c] = r_key[127-32*c -: 32];
    end
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_idx[j] = r_col_cnt + 2'(j);
      w_new[j] = (r_last ? w_in_col[w_idx[j]] : mix_column(w_in_col[w_idx[j]]))
                 ^ w_key_col[w_idx[j]];
    end
  end

  // Operands are only sampled on the accepting edge, so the block in flight is isolated from the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in   <= '0;
      r_key  <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_in   <= in;
      r_key  <= round_key;
      r_last <= last_round;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_col_cnt <= 2'd0;
      for (int c = 0; c < 4; c++) r_res[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_COLS;
            r_col_cnt <= 2'd0;
          end
        end
        S_COLS: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++) r_res[w_idx[j]] <= w_new[j];
          r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
          if (w_last_write) r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state   <= w_accept ? S_COLS : S_IDLE;
            r_col_cnt <= 2'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_add_round_key_stage.sv
// Scoreboard bench for mix_add_round_key_stage, with one instance for each
// legal COLS_PER_CYCLE (index d holds 1 << d columns per cycle).
module tb_mix_add_round_key_stage;

  localparam logic [127:0] R1_IN   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R10_IN  = 128'he9317db5cb322c723d2e895faf090794;
  localparam logic [127:0] R10_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid  [3];
  logic         inReady  [3];
  logic         lastRnd  [3];
  logic         outValid [3];
  logic         outReady [3];
  logic         busyOut  [3];
  logic [127:0] inData   [3];
  logic [127:0] keyData  [3];
  logic [127:0] outData  [3];

  int errors = 0;
  int checks = 0;
  logic [127:0] expQ[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_add_round_key_stage #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid[g]),
      .in_ready   (inReady[g]),
      .in         (inData[g]),
      .round_key  (keyData[g]),
      .last_round (lastRnd[g]),
      .out_valid  (outValid[g]),
      .out_ready  (outReady[g]),
      .out        (outData[g]),
      .busy       (busyOut[g])
    );
  end

  // Reference AddRoundKey(MixColumns) built from a generic GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic last);
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        b = last ? a[i] : gmul(8'h02, a[i]) ^ gmul(8'h03, a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
        r[127-32*c-8*i -: 8] = b ^ k[127-32*c-8*i -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offers a block and pushes its expected result once the DUT will take it.
  task automatic accept(input int d, input logic [127:0] data, input logic [127:0] key,
                        input logic last, input logic [127:0] expv, output bit ok);
    @(negedge clk);
    inData[d]  = data;
    keyData[d] = key;
    lastRnd[d] = last;
    inValid[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inReady[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      expQ.push_back(expv);
      @(posedge clk);
      #1;
    end
    inValid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (outValid[d] !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      inValid[d]  = 1'b0;
      outReady[d] = 1'b1;
      lastRnd[d]  = 1'b0;
      inData[d]   = '0;
      keyData[d]  = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (outValid[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid[%0d]: got %b expected 0", d, outValid[d]); end
      checks++;
      if (busyOut[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", d, busyOut[d]); end
      checks++;
      if (inReady[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready[%0d]: got %b expected 0", d, inReady[d]); end
      checks++;
      if (outData[d] !== 128'h0) begin errors++; $display("[TB] FAIL reset_out[%0d]: got %h expected 0", d, outData[d]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (inReady[d] !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready[%0d]: got %b expected 1", d, inReady[d]); end
    end
  endtask

  task automatic test_single_block(input int d, input string name, input logic [127:0] data,
                                   input logic [127:0] key, input logic last,
                                   input logic [127:0] expv);
    bit ok;
    int lat;
    logic [127:0] want;
    outReady[d] = 1'b1;
    accept(d, data, key, last, expv, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL %s_accept[%0d]: in_ready never rose", name, d); return; end
    checks++;
    if (busyOut[d] !== 1'b1 || inReady[d] !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_cols_flags[%0d]: busy=%b in_ready=%b expected busy=1 in_ready=0", name, d, busyOut[d], inReady[d]);
    end
    wait_valid(d, lat);
    checks++;
    if (lat != (4 >> d)) begin errors++; $display("[TB] FAIL %s_latency[%0d]: got %0d expected %0d", name, d, lat, 4 >> d); end
    checks++;
    if (expQ.size() == 0) begin errors++; $display("[TB] FAIL %s_scoreboard[%0d]: queue empty", name, d); return; end
    want = expQ.pop_front();
    if (outData[d] !== want) begin errors++; $display("[TB] FAIL %s_out[%0d]: got %h expected %h", name, d, outData[d], want); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [127:0] want;
    outReady[0] = 1'b0;
    accept(0, R1_IN, R1_KEY, 1'b0, R1_OUT, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_accept: in_ready never rose"); return; end
    wait_valid(0, lat);
    checks++;
    if (expQ.size() == 0) begin errors++; $display("[TB] FAIL bp_scoreboard: queue empty"); return; end
    want = expQ.pop_front();
    if (lat != 4) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_flags cycle %0d: out_valid=%b in_ready=%b expected 1/0", k, outValid[0], inReady[0]);
      end
      checks++;
      if (outData[0] !== want) begin errors++; $display("[TB] FAIL bp_out cycle %0d: got %h expected %h", k, outData[0], want); end
      @(negedge clk);
      inData[0]  = rand128();
      keyData[0] = rand128();
      lastRnd[0] = ~lastRnd[0];
      inValid[0] = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (outValid[0] !== 1'b0 || busyOut[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: out_valid=%b busy=%b expected 0/0", outValid[0], busyOut[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    logic [127:0] want;
    outReady[0] = 1'b1;
    accept(0, R1_IN, R1_KEY, 1'b0, R1_OUT, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL b2b_accept: in_ready never rose"); return; end
    inData[0]  = R10_IN;
    keyData[0] = R10_KEY;
    lastRnd[0] = 1'b1;
    inValid[0] = 1'b1;
    expQ.push_back(R10_OUT);
    wait_valid(0, lat);
    checks++;
    if (lat != 4) begin errors++; $display("[TB] FAIL b2b_latency1: got %0d expected 4", lat); end
    checks++;
    want = (expQ.size() != 0) ? expQ.pop_front() : 128'h0;
    if (outData[0] !== want) begin errors++; $display("[TB] FAIL b2b_out1: got %h expected %h", outData[0], want); end
    checks++;
    if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready_hold: got %b expected 1", inReady[0]); end
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    checks++;
    if (outValid[0] !== 1'b0 || busyOut[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_no_bubble: out_valid=%b busy=%b expected 0/1", outValid[0], busyOut[0]);
    end
    wait_valid(0, lat);
    checks++;
    if (lat != 4) begin errors++; $display("[TB] FAIL b2b_latency2: got %0d expected 4", lat); end
    checks++;
    want = (expQ.size() != 0) ? expQ.pop_front() : 128'h0;
    if (outData[0] !== want) begin errors++; $display("[TB] FAIL b2b_out2: got %h expected %h", outData[0], want); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [127:0] s, k;
    outReady[0] = 1'b1;
    accept(0, R1_IN, R1_KEY, 1'b0, R1_OUT, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rstmid_accept: in_ready never rose"); return; end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expQ.delete();
    checks++;
    if (outValid[0] !== 1'b0 || busyOut[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_flags: out_valid=%b busy=%b expected 0/0", outValid[0], busyOut[0]);
    end
    checks++;
    if (outData[0] !== 128'h0) begin errors++; $display("[TB] FAIL rstmid_out: got %h expected 0", outData[0]); end
    checks++;
    if (inReady[0] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_in_ready: got %b expected 0", inReady[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (inReady[0] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready_after: got %b expected 1", inReady[0]); end
    s = rand128();
    k = rand128();
    test_single_block(0, "rstmid_fresh", s, k, 1'b0, model(s, k, 1'b0));
  endtask

  task automatic test_random(input int d, input int n);
    logic [127:0] s, k;
    logic last;
    for (int i = 0; i < n; i++) begin
      s = rand128();
      k = rand128();
      last = 1'($urandom_range(0, 1));
      test_single_block(d, "random", s, k, last, model(s, k, last));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    for (int d = 0; d < 3; d++) begin
      test_single_block(d, "round1", R1_IN, R1_KEY, 1'b0, R1_OUT);
      test_single_block(d, "round10", R10_IN, R10_KEY, 1'b1, R10_OUT);
    end
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    for (int d = 0; d < 3; d++) test_random(d, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
